// File: rtl/wired_mul_arb_pkg.sv
// Shared MDU types for the multiplier arbiter and its requesters.
// Also holds the index-width helper used by the arbiter and the round-robin picker.
package wired_mul_arb_pkg;

  localparam int MUL_LAT_DEFAULT = 3;

  typedef enum logic [1:0] {
    MDU_MUL    = 2'd0,
    MDU_MULH   = 2'd1,
    MDU_MULHU  = 2'd2,
    MDU_MULHSU = 2'd3
  } mdu_op_e;

  typedef struct packed {
    mdu_op_e     op;
    logic [31:0] r0;
    logic [31:0] r1;
  } iq_mdu_req_t;

  typedef struct packed {
    logic [31:0] result;
  } iq_mdu_resp_t;

  // Width of an index into n requesters; never zero so that n=1 still has a legal vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wired_mul_arb_if.sv
// Requester-side bus between the MDU issue queues and wired_mul_arb.
// The slave modport is the arbiter; the master modport is the issue queues.
interface wired_mul_arb_if #(
  parameter int NUM_REQ = 2
);
  import wired_mul_arb_pkg::*;

  // Valid/ready: a request transfers on a cycle where req_valid_i[k] && req_ready_o[k];
  // a response transfers where resp_valid_o[k] && resp_ready_i[k]. Valid never waits on ready.
  logic [NUM_REQ-1:0] req_valid_i;
  logic [NUM_REQ-1:0] req_ready_o;
  iq_mdu_req_t        req_i [NUM_REQ];
  logic [NUM_REQ-1:0] resp_valid_o;
  logic [NUM_REQ-1:0] resp_ready_i;
  iq_mdu_resp_t       resp_o;

  modport slave (
    input  req_valid_i, req_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_o
  );

  modport master (
    output req_valid_i, req_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_o
  );

endinterface

// File: rtl/wired_rr_arb.sv
// Generic N-way round-robin picker: first set request at or above ptr_i, wrapping.
// Purely combinational; the caller owns and updates the pointer.
module wired_rr_arb
  import wired_mul_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int off = 0; off < N; off++) begin
      cand = IW'((int'(ptr_i) + off) % N);
      if (en_i && !any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/wired_mul_arb.sv
// Shares one pipelined multiplier between NUM_REQ MDU issue queues with round-robin issue
// and a shadow tag pipeline for response routing. Optional counters: WIRED_MUL_ARB_PERF_EN.
module wired_mul_arb
  import wired_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  wired_mul_arb_if.slave       bus,
  output logic                 mul_valid_o,
  output iq_mdu_req_t          mul_req_o,
  output logic                 mul_ready_o,
  input  logic                 mul_valid_i,
  input  iq_mdu_resp_t         mul_resp_i
`ifdef WIRED_MUL_ARB_PERF_EN
  ,
  output logic [31:0]          perf_grant_o [NUM_REQ],
  output logic [31:0]          perf_stall_o
`endif
);

  localparam int IW   = idx_w(NUM_REQ);
  localparam int HEAD = MUL_LAT - 1;

  logic [MUL_LAT-1:0] tag_v_q, tag_v_d;
  logic [IW-1:0]      tag_id_q [MUL_LAT];
  logic [IW-1:0]      tag_id_d [MUL_LAT];
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;

  logic               advance;
  logic               grant_en;
  logic               grant_any;
  logic [NUM_REQ-1:0] grant_oh;
  logic [IW-1:0]      grant_idx;

  // The whole multiplier advances only when the op at its head can leave.
  assign advance     = !tag_v_q[HEAD] || bus.resp_ready_i[tag_id_q[HEAD]];
  assign mul_ready_o = advance && !flush_i;
  assign grant_en    = advance && !flush_i && !rst;

  wired_rr_arb #(.N(NUM_REQ), .IW(IW)) u_rr_arb (
    .req_i (bus.req_valid_i),
    .ptr_i (rr_ptr_q),
    .en_i  (grant_en),
    .gnt_o (grant_oh),
    .idx_o (grant_idx),
    .any_o (grant_any)
  );

  assign bus.req_ready_o = grant_oh;
  assign mul_valid_o     = grant_any;
  assign mul_req_o       = grant_any ? bus.req_i[grant_idx] : '0;
  assign bus.resp_o      = mul_resp_i;

  always_comb begin
    bus.resp_valid_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (tag_v_q[HEAD] && (tag_id_q[HEAD] == IW'(k))) bus.resp_valid_o[k] = 1'b1;
    end
  end

  always_comb begin
    tag_v_d  = tag_v_q;
    tag_id_d = tag_id_q;
    rr_ptr_d = rr_ptr_q;
    if (flush_i) begin
      tag_v_d = '0;
    end else if (advance) begin
      tag_v_d[0]  = grant_any;
      tag_id_d[0] = grant_idx;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_v_d[i]  = tag_v_q[i-1];
        tag_id_d[i] = tag_id_q[i-1];
      end
      if (grant_any) rr_ptr_d = IW'((int'(grant_idx) + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v_q  <= '0;
      rr_ptr_q <= '0;
      for (int i = 0; i < MUL_LAT; i++) tag_id_q[i] <= '0;
    end else begin
      tag_v_q  <= tag_v_d;
      tag_id_q <= tag_id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef WIRED_MUL_ARB_PERF_EN
  logic [31:0] perf_grant_q [NUM_REQ];
  logic [31:0] perf_stall_q;

  // Counters survive flushes; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      for (int k = 0; k < NUM_REQ; k++) perf_grant_q[k] <= '0;
    end else begin
      if (grant_any) perf_grant_q[grant_idx] <= perf_grant_q[grant_idx] + 32'd1;
      if (tag_v_q[HEAD] && !advance) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_grant_o = perf_grant_q;
  assign perf_stall_o = perf_stall_q;
`endif

`ifndef SYNTHESIS
  head_matches_mul : assert property (@(posedge clk) disable iff (rst)
    mul_valid_i == tag_v_q[HEAD])
    else $error("multiplier valid_o disagrees with shadow tag head");
`endif

endmodule
